// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Iterative restoring divider. Divides a DW-bit unsigned
//                dividend by a VW-bit unsigned divisor, one quotient bit per
//                clock, MSB first, under a start/busy/done handshake.
//                Divide-by-zero returns an all-ones quotient, a zero
//                remainder and raises div_by_zero alongside done.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int DW = 5,
    parameter int VW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] c_cnt_load = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_dvd;   // dividend, shifted left one bit per step
    logic [VW-1:0] r_dvs;   // captured divisor
    logic [VW:0]   r_prem;  // partial remainder, one guard bit wide
    logic [DW-1:0] r_quo;   // quotient bits collected LSB-first
    logic [CW-1:0] r_cnt;   // steps remaining after the current one

    logic [VW:0]   w_trial;
    logic [VW:0]   w_dvs_ext;
    logic [VW:0]   w_diff;
    logic          w_ge;
    logic [VW:0]   w_rem_next;
    logic [DW-1:0] w_quo_next;

    // Guard bit of the partial remainder and the bit shifted out of the
    // quotient register never influence results; gathered here on purpose.
    logic          w_unused;

    // One restoring step: bring down the next dividend bit and subtract if it fits
    always_comb begin
        w_trial    = {r_prem[VW-1:0], r_dvd[DW-1]};
        w_dvs_ext  = {1'b0, r_dvs};
        w_diff     = w_trial - w_dvs_ext;
        w_ge       = (w_trial >= w_dvs_ext);
        w_rem_next = w_ge ? w_diff : w_trial;
        w_quo_next = {r_quo[DW-2:0], w_ge};
    end

    assign w_unused = r_prem[VW] ^ r_quo[DW-1];

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_dvd  <= dividend;
                        r_dvs  <= divisor;
                        r_prem <= '0;
                        r_quo  <= '0;
                        r_cnt  <= c_cnt_load;
                        busy   <= 1'b1;
                        if (divisor == '0) begin
                            // No iterations needed: result is known at accept
                            r_state     <= S_DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state     <= S_CALC;
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end

                S_CALC: begin
                    r_prem <= w_rem_next;
                    r_quo  <= w_quo_next;
                    r_dvd  <= {r_dvd[DW-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        // Final step: publish results so they are valid with done
                        r_state   <= S_DONE;
                        done      <= 1'b1;
                        quotient  <= w_quo_next;
                        remainder <= w_rem_next[VW-1:0];
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
